// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the RV32I core.
// Walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// driving fetch, IR latch, PC update, regfile write and a req/ack data port.
// Optional macro CPU_SEQUENCER_SINGLE_STEP_EN adds a 'step' input that runs
// exactly one instruction from IDLE while run is low.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             imem_ready,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_jmp,
  input  logic             dec_wen,
  input  logic             dec_halt,
  input  logic             dec_illegal,
  input  logic             dmem_ack,
  output logic             if_ce,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel_jmp,
  output logic             rf_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    TRAP   = 3'd7
  } state_t;

  localparam logic [7:0]       TMO_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [7:0]       tmo_cnt_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] instret_q;
  state_t           retire_next;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  logic step_mode_q;
`endif

  // Where an instruction goes once it retires: back to IDLE after a single step or when run has dropped
  always_comb begin
    retire_next = FETCH;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    if (step_mode_q || !run) retire_next = IDLE;
`else
    if (!run) retire_next = IDLE;
`endif
  end

  // Strobes decode straight from the current state; a store's ack cycle is also its retire cycle
  always_comb begin
    if_ce      = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel_jmp = 1'b0;
    rf_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if_ce = 1'b1;
        ir_we = imem_ready;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_store;
        pc_we    = dmem_ack & dec_store;
      end
      WB: begin
        rf_we      = dec_wen;
        pc_we      = 1'b1;
        pc_sel_jmp = dec_jmp;
      end
      default: ;
    endcase
  end

  // Next-state logic plus the retire counter, memory timeout counter and sticky trap cause
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= 8'd0;
      cause_q     <= 2'b00;
      instret_q   <= '0;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
      step_mode_q <= 1'b0;
`endif
    end else begin
      if (pc_we) begin
        instret_q <= instret_q + CNT_ONE;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        step_mode_q <= 1'b0;
`endif
      end
      unique case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
          end
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
          else if (step) begin
            state_q     <= FETCH;
            step_mode_q <= 1'b1;
          end
`endif
        end
        FETCH: begin
          if (imem_ready) state_q <= DECODE;
        end
        DECODE: begin
          if (dec_illegal) begin
            state_q <= TRAP;
            cause_q <= 2'b01;
          end else if (dec_halt) begin
            state_q <= HALT;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          tmo_cnt_q <= 8'd0;
          if (dec_load || dec_store) state_q <= MEM;
          else                       state_q <= WB;
        end
        MEM: begin
          if (dmem_ack) begin
            state_q <= dec_store ? retire_next : WB;
          end else if (tmo_cnt_q == TMO_LIMIT) begin
            state_q <= TRAP;
            cause_q <= 2'b10;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        WB: begin
          state_q <= retire_next;
        end
        default: ;
      endcase
    end
  end

  assign halted     = (state_q == HALT);
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed, self-checking bench for cpu_sequencer.
// Inputs change just after the rising edge, outputs are sampled 2 time units later.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, imem_ready;
  logic        dec_load, dec_store, dec_jmp, dec_wen, dec_halt, dec_illegal, dmem_ack;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  logic        step;
`endif
  logic        if_ce, ir_we, pc_we, pc_sel_jmp, rf_we, dmem_req, dmem_we, halted, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  // {if_ce, ir_we, pc_we, pc_sel_jmp, rf_we, dmem_req, dmem_we, halted, trap}
  wire [8:0] strobes = {if_ce, ir_we, pc_we, pc_sel_jmp, rf_we, dmem_req, dmem_we, halted, trap};

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_ready(imem_ready), .dec_load(dec_load), .dec_store(dec_store),
    .dec_jmp(dec_jmp), .dec_wen(dec_wen), .dec_halt(dec_halt),
    .dec_illegal(dec_illegal), .dmem_ack(dmem_ack),
    .if_ce(if_ce), .ir_we(ir_we), .pc_we(pc_we), .pc_sel_jmp(pc_sel_jmp),
    .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .halted(halted),
    .trap(trap), .trap_cause(trap_cause), .state(state), .instret(instret)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    run = 0; imem_ready = 0; dec_load = 0; dec_store = 0; dec_jmp = 0;
    dec_wen = 0; dec_halt = 0; dec_illegal = 0; dmem_ack = 0;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    step = 0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++; if (strobes !== 9'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 000000000", strobes); end
    checks++; if (trap_cause !== 2'b00) begin errors++; $display("[TB] FAIL reset_cause: got %b expected 00", trap_cause); end
    checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret); end
    tick(); tick();
    checks++; if (state !== 3'd0 || strobes !== 9'b0) begin errors++; $display("[TB] FAIL idle_hold: got state %0d strobes %b expected 0 / 0", state, strobes); end
  endtask

  task automatic test_alu_op();
    logic [2:0] exp_state [4];
    logic [8:0] exp_strb  [4];
    exp_state = '{3'd1, 3'd2, 3'd3, 3'd5};
    exp_strb  = '{9'b110000000, 9'b000000000, 9'b000000000, 9'b001010000};
    do_reset();
    run = 1; imem_ready = 1; dec_wen = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (state !== exp_state[c]) begin errors++; $display("[TB] FAIL alu_state[%0d]: got %0d expected %0d", c, state, exp_state[c]); end
      checks++; if (strobes !== exp_strb[c]) begin errors++; $display("[TB] FAIL alu_strobes[%0d]: got %b expected %b", c, strobes, exp_strb[c]); end
    end
    checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL alu_instret_pre: got %0d expected 0", instret); end
    tick();
    checks++; if (state !== 3'd1 || instret !== 32'd1) begin errors++; $display("[TB] FAIL alu_retire: got state %0d instret %0d expected 1 / 1", state, instret); end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    run = 1; imem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (state !== 3'd1 || if_ce !== 1'b1 || ir_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wait[%0d]: got state %0d if_ce %b ir_we %b expected 1 1 0", c, state, if_ce, ir_we); end
    end
    imem_ready = 1; settle();
    checks++; if (ir_we !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ready_irwe: got %b expected 1", ir_we); end
    tick();
    checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL fetch_to_decode: got %0d expected 2", state); end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    do_reset();
    run = 1; imem_ready = 1; dec_load = 1; dec_wen = 1;
    tick(); tick(); tick();
    checks++; if (state !== 3'd3 || dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL load_exec: got state %0d req %b expected 3 / 0", state, dmem_req); end
    tick();
    for (int k = 1; k <= 3; k++) begin
      dmem_ack = (k == 3); settle();
      if (dmem_req === 1'b1) req_cycles++;
      checks++; if (state !== 3'd4 || dmem_we !== 1'b0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL load_mem[%0d]: got state %0d we %b pc_we %b rf_we %b expected 4 0 0 0", k, state, dmem_we, pc_we, rf_we); end
      tick();
    end
    dmem_ack = 0; run = 0; settle();
    checks++; if (req_cycles != 3) begin errors++; $display("[TB] FAIL load_req_cycles: got %0d expected 3", req_cycles); end
    checks++; if (state !== 3'd5 || strobes !== 9'b001010000) begin errors++; $display("[TB] FAIL load_wb: got state %0d strobes %b expected 5 / 001010000", state, strobes); end
    tick();
    checks++; if (state !== 3'd0 || instret !== 32'd1) begin errors++; $display("[TB] FAIL load_retire: got state %0d instret %0d expected 0 / 1", state, instret); end
  endtask

  task automatic test_store_timeout();
    int req_cycles = 0;
    do_reset();
    run = 1; imem_ready = 1; dec_store = 1;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 16; k++) begin
      if (state === 3'd4 && dmem_req === 1'b1 && dmem_we === 1'b1 && pc_we === 1'b0) req_cycles++;
      tick();
    end
    checks++; if (req_cycles != 16) begin errors++; $display("[TB] FAIL store_tmo_req_cycles: got %0d expected 16", req_cycles); end
    checks++; if (state !== 3'd7 || trap_cause !== 2'b10) begin errors++; $display("[TB] FAIL store_tmo_trap: got state %0d cause %b expected 7 / 10", state, trap_cause); end
    dmem_ack = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (state !== 3'd7 || strobes !== 9'b000000001 || trap_cause !== 2'b10) begin errors++; $display("[TB] FAIL trap_absorb[%0d]: got state %0d strobes %b cause %b expected 7 000000001 10", c, state, strobes, trap_cause); end
    end
    checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL store_tmo_instret: got %0d expected 0", instret); end
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    run = 1; imem_ready = 1; dec_store = 1;
    tick(); tick(); tick();
    run = 0;
    tick();
    for (int k = 0; k < 15; k++) tick();
    dmem_ack = 1; settle();
    checks++; if (state !== 3'd4 || strobes !== 9'b001001100) begin errors++; $display("[TB] FAIL ack_tmo_retire: got state %0d strobes %b expected 4 / 001001100", state, strobes); end
    tick();
    dmem_ack = 0; settle();
    checks++; if (state !== 3'd0 || trap !== 1'b0 || instret !== 32'd1) begin errors++; $display("[TB] FAIL ack_tmo_idle: got state %0d trap %b instret %0d expected 0 0 1", state, trap, instret); end
  endtask

  task automatic test_illegal_priority();
    do_reset();
    run = 1; imem_ready = 1; dec_illegal = 1; dec_halt = 1;
    tick(); tick(); tick();
    checks++; if (state !== 3'd7 || trap_cause !== 2'b01 || halted !== 1'b0 || trap !== 1'b1) begin errors++; $display("[TB] FAIL illegal_prio: got state %0d cause %b halted %b trap %b expected 7 01 0 1", state, trap_cause, halted, trap); end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1; imem_ready = 1; dec_halt = 1;
    tick(); tick(); tick();
    checks++; if (state !== 3'd6 || strobes !== 9'b000000010 || trap_cause !== 2'b00) begin errors++; $display("[TB] FAIL halt_enter: got state %0d strobes %b cause %b expected 6 000000010 00", state, strobes, trap_cause); end
    tick(); tick();
    checks++; if (state !== 3'd6 || halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_absorb: got state %0d halted %b expected 6 / 1", state, halted); end
  endtask

  task automatic test_jmp_run_drop();
    do_reset();
    run = 1; imem_ready = 1; dec_jmp = 1;
    tick(); tick(); tick();
    run = 0;
    tick();
    checks++; if (state !== 3'd5 || strobes !== 9'b001100000) begin errors++; $display("[TB] FAIL jmp_wb: got state %0d strobes %b expected 5 / 001100000", state, strobes); end
    tick();
    checks++; if (state !== 3'd0 || instret !== 32'd1) begin errors++; $display("[TB] FAIL jmp_idle: got state %0d instret %0d expected 0 / 1", state, instret); end
  endtask

  task automatic test_reset_in_mem();
    run = 1; dec_jmp = 0; dec_load = 1;
    tick(); tick(); tick(); tick();
    checks++; if (state !== 3'd4 || dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mem_pre: got state %0d req %b expected 4 / 1", state, dmem_req); end
    rst = 1;
    tick();
    checks++; if (state !== 3'd0 || dmem_req !== 1'b0 || instret !== 32'd0) begin errors++; $display("[TB] FAIL rst_mem_post: got state %0d req %b instret %0d expected 0 0 0", state, dmem_req, instret); end
    rst = 0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_state [4];
    exp_state = '{3'd1, 3'd2, 3'd3, 3'd5};
    do_reset();
    run = 1; imem_ready = 1; dec_wen = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (state !== exp_state[c % 4] || pc_we !== ((c % 4) == 3)) begin errors++; $display("[TB] FAIL b2b[%0d]: got state %0d pc_we %b expected %0d %b", c, state, pc_we, exp_state[c % 4], ((c % 4) == 3)); end
    end
    tick();
    checks++; if (instret !== 32'd3) begin errors++; $display("[TB] FAIL b2b_instret: got %0d expected 3", instret); end
  endtask

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    step = 1;
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL step_start: got %0d expected 1", state); end
    tick(); tick();
    step = 0; imem_ready = 1; dec_wen = 1;
    tick(); tick(); tick();
    checks++; if (state !== 3'd5 || pc_we !== 1'b1) begin errors++; $display("[TB] FAIL step_wb: got state %0d pc_we %b expected 5 / 1", state, pc_we); end
    tick();
    checks++; if (state !== 3'd0 || instret !== 32'd1) begin errors++; $display("[TB] FAIL step_retire: got state %0d instret %0d expected 0 / 1", state, instret); end
    tick(); tick();
    checks++; if (state !== 3'd0 || instret !== 32'd1) begin errors++; $display("[TB] FAIL step_stay_idle: got state %0d instret %0d expected 0 / 1", state, instret); end
  endtask
`endif

  // Watchdog so the run always ends even if something wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_alu_op();
    test_fetch_wait();
    test_load();
    test_store_timeout();
    test_ack_at_timeout();
    test_illegal_priority();
    test_halt();
    test_jmp_run_drop();
    test_reset_in_mem();
    test_back_to_back();
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
